decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32 decode stage sitting between IF/ID and EX.
//  Decodes one instruction per cycle into the extended control bundle, generates the immediate and flags illegal encodings.
//  Inserts load-use bubbles on a parametrised stall counter.
//  Connects to fetch and execute through valid/ready handshakes, with a flush input from branch resolution.
// PARAMETERS
//  XLEN          32  datapath width of pc/imm outputs (32 or 64; imm sign-extended to XLEN)
//  ENABLE_M      0   1: decode M-extension (funct7=0000001 on opcode 0110011); 0: those encodings are illegal
//  STALL_CYCLES  1   bubbles inserted per load-use hazard (1..3)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  in_valid     in   1        fetch presents in_instr/in_pc
//  in_ready     out  1        stage accepts input this cycle
//  in_instr     in   32       raw instruction
//  in_pc        in   XLEN     pc of in_instr
//  flush        in   1        kill held and incoming instruction
//  out_valid    out  1        out_* holds a decoded instruction
//  out_ready    in   1        EX consumes out_* this cycle
//  out_ctrl     out  ctrl_ex_t  decoded control bundle (see STRUCTURE)
//  out_imm      out  XLEN     sign-extended immediate per imm_sel (0 for IMM_NONE)
//  out_pc       out  XLEN     pc of held instruction
//  out_illegal  out  1        held instruction is illegal
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0, out_illegal=0, out_imm=0, out_pc=0, stall counter=0.
//   - out_ctrl=NOP: ALU_ADD, regwen=0, IMM_NONE, SRC_A_RS1, SRC_B_RS2, MEM_NONE, BR_NONE, WB_ALU, regs 0.
//  Handshake: single output register, latency 1.
//   - in_ready = !flush && stall_cnt==0 && !hazard && (!out_valid || out_ready).
//   - Accept on in_valid&&in_ready: output register loads the decode result next edge, out_valid=1.
//   - Held data stays stable while out_valid&&!out_ready.
//   - out_valid&&out_ready with no accept: out_valid->0. Consume and accept in the same cycle: register is replaced, no bubble.
//  Decode: same ALU/imm/A/B mapping as the base decoder, plus:
//   - mem_op: LB/LH/LW/LBU/LHU/SB/SH/SW from funct3.
//   - br_op: BEQ..BGEU; JAL, JALR.
//   - wb_sel: ALU, MEM, PC4 (JAL/JALR).
//   - ENABLE_M ops: ALU_MUL..ALU_REMU.
//  Operand usage:
//   - use_rs1 for R, I-ALU, LOAD, STORE, BRANCH, JALR.
//   - use_rs2 for R, STORE, BRANCH.
//   - Unused rs fields are reported as 0.
//  regwen is forced 0 when rd==0.
//  Illegal:
//   - Conditions: in_instr[1:0]!=2'b11, unknown opcode, undefined funct3/funct7 combination (incl. M when ENABLE_M=0), SLLI/SRLI/SRAI with bad funct7.
//   - Illegal instructions still pass through with out_illegal=1, regwen=0, mem_op=MEM_NONE, br_op=BR_NONE.
//  ECALL/EBREAK/FENCE: legal NOPs, system flag set.
//  Load-use hazard: hazard = in_valid && out_valid && out_ctrl.mem_op is a load && out_ctrl.rd!=0 && ((use_rs1 && rs1==out rd) || (use_rs2 && rs2==out rd)).
//   - While hazard && out_ready: held load drains, out_valid->0, stall_cnt loads STALL_CYCLES-1.
//   - While stall_cnt>0: in_ready=0, stall_cnt decrements each cycle.
//   - Total bubbles per hazard = STALL_CYCLES.
//   - Hazard && !out_ready: plain back-pressure, counter untouched.
//  Flush (sync, highest priority):
//   - Next edge out_valid=0 and stall_cnt=0.
//   - in_ready=0 during the flush cycle, so the incoming instruction is dropped.
//  Reset mid-operation: all state returns to reset values immediately; no partial output.
// STRUCTURE
//  In control_pkg:
//   - Extend alu_op_e with ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
//   - Add mem_op_e, br_op_e, wb_sel_e.
//   - Add ctrl_ex_t = control_signals_t fields + mem_op, br_op, wb_sel, use_rs1, use_rs2, system.
//   - Add localparam CTRL_NOP and opcode constants.
//  Sub-module instr_decoder (combinational, ENABLE_M param):
//   - Inputs: instr. Outputs: ctrl_ex_t, imm (XLEN), illegal.
//  decode_stage holds the register, handshake, hazard and stall counter.
// TESTING
//  1. Pipeline flow: stream addi x1,x0,5 (0x00500093) with out_ready=1.
//     -> 1 cycle later: out_valid=1, ALU_ADD, SRC_B_IMM, imm=5, regwen=1, rd=1.
//  2. Load-use: lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3).
//     -> Exactly STALL_CYCLES cycles with out_valid=0 between them; run with STALL_CYCLES=1 and 3.
//  3. Back-pressure: hold out_ready=0 for 4 cycles with in_valid=1.
//     -> in_ready=0; out_* stable; no instruction lost or duplicated after release.
//  4. M-extension: mul x3,x1,x2 (0x022081B3).
//     -> ENABLE_M=1: ALU_MUL, illegal=0. ENABLE_M=0: out_illegal=1, regwen=0.
//  5. Illegal and x0 writes: 0xFFFFFFFF -> out_illegal=1; addi x0,x0,1 (0x00100013) -> regwen=0, illegal=0.
//  6. Flush and reset:
//     - Flush while a load is held and a stall is pending -> next cycle out_valid=0, stall_cnt=0, in_ready=1.
//     - rst_n low mid-stream -> reset values immediately.

Source files
------------

// File: rtl/control_pkg.sv
// Shared decode types for the ID stage: ALU/memory/branch/writeback encodings,
// the control bundle handed to EX, its NOP value and the RV32 opcode map.
package control_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
    typedef enum logic {SRC_B_RS2, SRC_B_IMM} src_b_e;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_e;

    typedef enum logic [3:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
    } br_op_e;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       regwen;
        imm_sel_e   imm_sel;
        src_a_e     src_a;
        src_b_e     src_b;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } control_signals_t;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       regwen;
        imm_sel_e   imm_sel;
        src_a_e     src_a;
        src_b_e     src_b;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        mem_op_e    mem_op;
        br_op_e     br_op;
        wb_sel_e    wb_sel;
        logic       use_rs1;
        logic       use_rs2;
        logic       system;
    } ctrl_ex_t;

    localparam ctrl_ex_t CTRL_NOP = '{
        alu_op: ALU_ADD, regwen: 1'b0, imm_sel: IMM_NONE, src_a: SRC_A_RS1,
        src_b: SRC_B_RS2, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, mem_op: MEM_NONE,
        br_op: BR_NONE, wb_sel: WB_ALU, use_rs1: 1'b0, use_rs2: 1'b0, system: 1'b0
    };

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Base integer ALU mapping; alt selects SUB/SRA on the funct7[5] variants.
    function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e alu_mext(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

    function automatic logic is_load(input mem_op_e m);
        return m inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32 decoder: raw instruction to EX control bundle, immediate
// and illegal flag. Illegal encodings are neutralised so they cannot write or branch.
module instr_decoder
    import control_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0
) (
    input  logic [31:0]     instr,
    output ctrl_ex_t        ctrl,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        writes;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        writes  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                writes = 1'b1; ctrl.imm_sel = IMM_U;
                ctrl.src_a = SRC_A_ZERO; ctrl.src_b = SRC_B_IMM;
            end
            OPC_AUIPC: begin
                writes = 1'b1; ctrl.imm_sel = IMM_U;
                ctrl.src_a = SRC_A_PC; ctrl.src_b = SRC_B_IMM;
            end
            OPC_JAL: begin
                writes = 1'b1; ctrl.imm_sel = IMM_J; ctrl.src_a = SRC_A_PC;
                ctrl.src_b = SRC_B_IMM; ctrl.br_op = BR_JAL; ctrl.wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                writes = 1'b1; ctrl.imm_sel = IMM_I; ctrl.src_b = SRC_B_IMM;
                ctrl.use_rs1 = 1'b1; ctrl.br_op = BR_JALR; ctrl.wb_sel = WB_PC4;
                illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl.imm_sel = IMM_B; ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  begin ctrl.br_op = BR_BEQ;  ctrl.alu_op = ALU_SUB;  end
                    3'b001:  begin ctrl.br_op = BR_BNE;  ctrl.alu_op = ALU_SUB;  end
                    3'b100:  begin ctrl.br_op = BR_BLT;  ctrl.alu_op = ALU_SLT;  end
                    3'b101:  begin ctrl.br_op = BR_BGE;  ctrl.alu_op = ALU_SLT;  end
                    3'b110:  begin ctrl.br_op = BR_BLTU; ctrl.alu_op = ALU_SLTU; end
                    3'b111:  begin ctrl.br_op = BR_BGEU; ctrl.alu_op = ALU_SLTU; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                writes = 1'b1; ctrl.imm_sel = IMM_I; ctrl.src_b = SRC_B_IMM;
                ctrl.use_rs1 = 1'b1; ctrl.wb_sel = WB_MEM;
                case (funct3)
                    3'b000:  ctrl.mem_op = MEM_LB;
                    3'b001:  ctrl.mem_op = MEM_LH;
                    3'b010:  ctrl.mem_op = MEM_LW;
                    3'b100:  ctrl.mem_op = MEM_LBU;
                    3'b101:  ctrl.mem_op = MEM_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                ctrl.imm_sel = IMM_S; ctrl.src_b = SRC_B_IMM;
                ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
                case (funct3)
                    3'b000:  ctrl.mem_op = MEM_SB;
                    3'b001:  ctrl.mem_op = MEM_SH;
                    3'b010:  ctrl.mem_op = MEM_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                writes = 1'b1; ctrl.imm_sel = IMM_I; ctrl.src_b = SRC_B_IMM; ctrl.use_rs1 = 1'b1;
                ctrl.alu_op = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_OP: begin
                writes = 1'b1; ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
                if (funct7 == 7'b0000000)
                    ctrl.alu_op = alu_base(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    ctrl.alu_op = alu_base(funct3, 1'b1);
                else if (funct7 == 7'b0000001 && ENABLE_M != 0)
                    ctrl.alu_op = alu_mext(funct3);
                else
                    illegal = 1'b1;
            end
            OPC_MISC_MEM: begin
                ctrl.system = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                // ECALL and EBREAK decode as legal; every other SYSTEM encoding is flagged illegal.
                ctrl.system = 1'b1;
                illegal = (instr[31:7] != 25'h0) && (instr[31:7] != 25'h0002000);
            end
            default: illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            illegal = 1'b1;
        ctrl.rs1    = ctrl.use_rs1 ? instr[19:15] : 5'd0;
        ctrl.rs2    = ctrl.use_rs2 ? instr[24:20] : 5'd0;
        ctrl.rd     = writes ? instr[11:7] : 5'd0;
        ctrl.regwen = writes && (ctrl.rd != 5'd0) && !illegal;
        if (illegal) begin
            ctrl.mem_op = MEM_NONE;
            ctrl.br_op  = BR_NONE;
        end
    end

    always_comb begin
        case (ctrl.imm_sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: one output register behind valid/ready, with load-use
// bubble insertion via a stall counter and a flush from branch resolution.
module decode_stage
    import control_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ENABLE_M     = 0,
    parameter int STALL_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_ex_t        out_ctrl,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    ctrl_ex_t        dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic [1:0]      stall_cnt;
    logic            hazard;
    logic            accept;

    instr_decoder #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_decoder (
        .instr   (in_instr),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Unused source fields decode to 0, so a held load to rd!=0 cannot match them.
    assign hazard = in_valid && out_valid && is_load(out_ctrl.mem_op) && (out_ctrl.rd != 5'd0)
                    && ((dec_ctrl.use_rs1 && dec_ctrl.rs1 == out_ctrl.rd)
                     || (dec_ctrl.use_rs2 && dec_ctrl.rs2 == out_ctrl.rd));

    assign in_ready = !flush && (stall_cnt == 2'd0) && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Draining the load starts the bubble; the counter covers the remaining STALL_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_ctrl    <= CTRL_NOP;
            out_imm     <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
            stall_cnt   <= 2'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
            stall_cnt <= 2'd0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_ctrl    <= dec_ctrl;
            out_imm     <= dec_imm;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal;
        end else if (hazard && out_ready) begin
            out_valid <= 1'b0;
            stall_cnt <= 2'(STALL_CYCLES - 1);
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (stall_cnt != 2'd0)
                stall_cnt <= stall_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances (M on / 1 bubble, M off / 3 bubbles)
// share the stimulus; expected values are hand-computed from the instruction encodings.
module tb_decode_stage;
    import control_pkg::*;

    localparam logic [31:0] LW_X2  = 32'h0000A103;
    localparam logic [31:0] ADD_X3 = 32'h001101B3;
    localparam logic [31:0] MUL_X3 = 32'h022081B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    ctrl_ex_t    a_out_ctrl;
    logic [31:0] a_out_imm, a_out_pc;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    ctrl_ex_t    b_out_ctrl;
    logic [31:0] b_out_imm, b_out_pc;

    logic        sel_b = 1'b0;
    logic        s_in_ready, s_out_valid;
    ctrl_ex_t    s_out_ctrl;
    logic [31:0] s_out_pc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic        rw;
        logic [31:0] imm;
        mem_op_e     mem;
        br_op_e      br;
        logic        b_ill;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ENABLE_M(1), .STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_imm(a_out_imm),
        .out_pc(a_out_pc), .out_illegal(a_out_illegal)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(0), .STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_imm(b_out_imm),
        .out_pc(b_out_pc), .out_illegal(b_out_illegal)
    );

    assign s_in_ready  = sel_b ? b_in_ready  : a_in_ready;
    assign s_out_valid = sel_b ? b_out_valid : a_out_valid;
    assign s_out_ctrl  = sel_b ? b_out_ctrl  : a_out_ctrl;
    assign s_out_pc    = sel_b ? b_out_pc    : a_out_pc;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic runLoadUse(input logic use_b, input int exp_bubbles, input string tag);
        int   bubbles;
        logic add_seen;
        logic accepted;
        bubbles  = 0;
        add_seen = 1'b0;
        sel_b    = use_b;
        doReset();
        applyStimulus(1'b1, LW_X2, 32'h300, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, ADD_X3, 32'h304, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_load_op"}, s_out_ctrl.mem_op, MEM_LW);
        checkOutput({tag, "_hazard_ready"}, s_in_ready, 1'b0);
        for (int c = 0; c < 20 && !add_seen; c++) begin
            if (c > 0) @(negedge clk);
            if (s_out_valid && s_out_pc == 32'h304) add_seen = 1'b1;
            else if (!s_out_valid) bubbles++;
            accepted = s_in_ready;
            if (!add_seen) begin
                cycle();
                if (accepted) in_valid = 1'b0;
            end
        end
        checkOutput({tag, "_add_seen"}, add_seen, 1'b1);
        checkOutput({tag, "_bubbles"}, bubbles, exp_bubbles);
        checkOutput({tag, "_add_rd"}, s_out_ctrl.rd, 5'd3);
        checkOutput({tag, "_add_rs1"}, s_out_ctrl.rs1, 5'd2);
        checkOutput({tag, "_add_rs2"}, s_out_ctrl.rs2, 5'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2;
        checkOutput("reset_valid", a_out_valid, 1'b0);
        checkOutput("reset_illegal", a_out_illegal, 1'b0);
        checkOutput("reset_imm", a_out_imm, 32'h0);
        checkOutput("reset_pc", a_out_pc, 32'h0);
        checkOutput("reset_alu", a_out_ctrl.alu_op, ALU_ADD);
        checkOutput("reset_regwen", a_out_ctrl.regwen, 1'b0);
        checkOutput("reset_srcb", a_out_ctrl.src_b, SRC_B_RS2);
        checkOutput("reset_wb", a_out_ctrl.wb_sel, WB_ALU);
        checkOutput("reset_b_valid", b_out_valid, 1'b0);
        cycle();
        rst_n = 1'b1;

        // instr, illegal, regwen, imm, mem_op, br_op, illegal on the M-less instance
        vq.push_back('{32'h00500093, 1'b0, 1'b1, 32'h00000005, MEM_NONE, BR_NONE, 1'b0});
        vq.push_back('{32'h00100013, 1'b0, 1'b0, 32'h00000001, MEM_NONE, BR_NONE, 1'b0});
        vq.push_back('{32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, MEM_NONE, BR_NONE, 1'b1});
        vq.push_back('{32'h00500090, 1'b1, 1'b0, 32'h00000000, MEM_NONE, BR_NONE, 1'b1});
        vq.push_back('{32'h04109093, 1'b1, 1'b0, 32'h00000041, MEM_NONE, BR_NONE, 1'b1});
        vq.push_back('{32'hFE20AE23, 1'b0, 1'b0, 32'hFFFFFFFC, MEM_SW,   BR_NONE, 1'b0});
        vq.push_back('{32'h008000EF, 1'b0, 1'b1, 32'h00000008, MEM_NONE, BR_JAL,  1'b0});
        vq.push_back('{32'h123452B7, 1'b0, 1'b1, 32'h12345000, MEM_NONE, BR_NONE, 1'b0});
        vq.push_back('{32'h00000073, 1'b0, 1'b0, 32'h00000000, MEM_NONE, BR_NONE, 1'b0});
        vq.push_back('{MUL_X3,       1'b0, 1'b1, 32'h00000000, MEM_NONE, BR_NONE, 1'b1});
        vq.push_back('{32'hFE208EE3, 1'b0, 1'b0, 32'hFFFFFFFC, MEM_NONE, BR_BEQ,  1'b0});
        vq.push_back('{32'h4010A133, 1'b1, 1'b0, 32'h00000000, MEM_NONE, BR_NONE, 1'b1});
        vq.push_back('{LW_X2,        1'b0, 1'b1, 32'h00000000, MEM_LW,   BR_NONE, 1'b0});

        $display("[TB] decode stream");
        for (int k = 0; k <= vq.size(); k++) begin
            if (k < vq.size()) applyStimulus(1'b1, vq[k].instr, 32'h1000 + 32'(4 * k), 1'b1, 1'b0);
            else applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            if (k < vq.size()) checkOutput("stream_in_ready", a_in_ready, 1'b1);
            if (k > 0) begin
                checkOutput("stream_valid", a_out_valid, 1'b1);
                checkOutput("stream_pc", a_out_pc, 32'h1000 + 32'(4 * (k - 1)));
                checkOutput("stream_illegal", a_out_illegal, vq[k-1].ill);
                checkOutput("stream_regwen", a_out_ctrl.regwen, vq[k-1].rw);
                checkOutput("stream_imm", a_out_imm, vq[k-1].imm);
                checkOutput("stream_mem", a_out_ctrl.mem_op, vq[k-1].mem);
                checkOutput("stream_br", a_out_ctrl.br_op, vq[k-1].br);
                checkOutput("stream_b_illegal", b_out_illegal, vq[k-1].b_ill);
                if (k == 1) begin
                    checkOutput("addi_alu", a_out_ctrl.alu_op, ALU_ADD);
                    checkOutput("addi_srcb", a_out_ctrl.src_b, SRC_B_IMM);
                    checkOutput("addi_rd", a_out_ctrl.rd, 5'd1);
                end
                if (vq[k-1].instr == MUL_X3) begin
                    checkOutput("mul_alu", a_out_ctrl.alu_op, ALU_MUL);
                    checkOutput("mul_b_regwen", b_out_ctrl.regwen, 1'b0);
                end
                if (vq[k-1].instr == 32'h00000073)
                    checkOutput("ecall_system", a_out_ctrl.system, 1'b1);
                if (vq[k-1].instr == 32'h008000EF)
                    checkOutput("jal_wb", a_out_ctrl.wb_sel, WB_PC4);
            end
            cycle();
        end
        @(negedge clk);
        checkOutput("stream_drained", a_out_valid, 1'b0);

        $display("[TB] back-pressure");
        sel_b = 1'b0;
        doReset();
        applyStimulus(1'b1, 32'h00500093, 32'h200, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 32'h00A00113, 32'h204, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", a_in_ready, 1'b0);
            checkOutput("bp_valid", a_out_valid, 1'b1);
            checkOutput("bp_pc", a_out_pc, 32'h200);
            checkOutput("bp_imm", a_out_imm, 32'd5);
            cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", a_in_ready, 1'b1);
        checkOutput("bp_release_pc", a_out_pc, 32'h200);
        cycle();
        applyStimulus(1'b1, 32'h00F00193, 32'h208, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_second_pc", a_out_pc, 32'h204);
        checkOutput("bp_second_imm", a_out_imm, 32'd10);
        checkOutput("bp_second_ready", a_in_ready, 1'b1);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_third_pc", a_out_pc, 32'h208);
        checkOutput("bp_third_imm", a_out_imm, 32'd15);
        cycle();
        @(negedge clk);
        checkOutput("bp_empty", a_out_valid, 1'b0);

        $display("[TB] load-use");
        runLoadUse(1'b0, 1, "lu_s1");
        runLoadUse(1'b1, 3, "lu_s3");

        $display("[TB] flush");
        sel_b = 1'b1;
        doReset();
        applyStimulus(1'b1, LW_X2, 32'h400, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, ADD_X3, 32'h404, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush_in_ready", s_in_ready, 1'b0);
        checkOutput("flush_load_held", s_out_valid, 1'b1);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush_valid", s_out_valid, 1'b0);
        checkOutput("flush_ready_after", s_in_ready, 1'b1);

        doReset();
        applyStimulus(1'b1, LW_X2, 32'h500, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, ADD_X3, 32'h504, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, ADD_X3, 32'h504, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush_stall_in_ready", s_in_ready, 1'b0);
        cycle();
        applyStimulus(1'b1, ADD_X3, 32'h504, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush_stall_cleared", s_in_ready, 1'b1);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush_stall_add_valid", s_out_valid, 1'b1);
        checkOutput("flush_stall_add_pc", s_out_pc, 32'h504);

        $display("[TB] reset mid-stream");
        sel_b = 1'b0;
        doReset();
        applyStimulus(1'b1, 32'h00500093, 32'h600, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_pre_valid", a_out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", a_out_valid, 1'b0);
        checkOutput("midrst_pc", a_out_pc, 32'h0);
        checkOutput("midrst_imm", a_out_imm, 32'h0);
        checkOutput("midrst_regwen", a_out_ctrl.regwen, 1'b0);
        checkOutput("midrst_rd", a_out_ctrl.rd, 5'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
